// File: rtl/async_fifo_wr_ctrl_pkg.sv
// Shared helpers for the async FIFO family: pointer container type and
// width-agnostic binary/Gray conversions (operands are zero-extended into ptr_t).
package async_fifo_pkg;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; upper zero bits leave narrow values intact.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int i = 1; i < PTR_MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_wr_ctrl_graycode_decoder.sv
// Combinational Gray-to-binary decoder; each binary bit is the XOR of all
// Gray bits at or above it.
module graycode_decoder #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  logic [W-1:0] bin;

  always_comb begin
    bin        = '0;
    bin[W-1]   = gray_i[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray_i[i];
    end
  end

  assign bin_o = bin;

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer controller for the async FIFO: write address/strobe,
// registered Gray pointer for CDC, read-pointer synchroniser, full/level flags.
module async_fifo_wr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 6
) (
  input  logic              clk_tx,
  input  logic              rst_tx,
  input  logic              push,
  input  logic              clr_ovf,
  input  logic [ADDR_W:0]   rd_ptr_gray_async,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);

  localparam int PW = ADDR_W + 1;
  localparam logic [ADDR_W:0] AF_LVL = AF_THRESH[ADDR_W:0];

  logic [ADDR_W:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W:0] wr_ptr_gray_q, wr_ptr_gray_d;
  logic [ADDR_W:0] sync_q [SYNC_STAGES];
  logic [ADDR_W:0] sync_d [SYNC_STAGES];
  logic            overflow_q, overflow_d;

  logic [ADDR_W:0] wr_gray;
  logic [ADDR_W:0] rq;
  logic [ADDR_W:0] rq_bin;
  logic [ADDR_W:0] level_w;
  logic            full_w;
  logic            push_ok;
  ptr_t            gray_wide;
  logic            unused_gray_hi;

  assign gray_wide      = bin2gray(ptr_t'(wr_cnt_q));
  assign wr_gray        = gray_wide[ADDR_W:0];
  assign unused_gray_hi = ^gray_wide[PTR_MAX_W-1:PW];

  assign rq = sync_q[SYNC_STAGES-1];

  graycode_decoder #(.W(PW)) u_rq_dec (
    .gray_i (rq),
    .bin_o  (rq_bin)
  );

  // Full when the write pointer is exactly one lap ahead of the synced read pointer.
  assign full_w  = (wr_gray == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]});
  assign level_w = wr_cnt_q - rq_bin;
  assign push_ok = push & ~full_w & ~rst_tx;

  always_comb begin
    wr_cnt_d      = wr_cnt_q + {{ADDR_W{1'b0}}, push_ok};
    wr_ptr_gray_d = wr_gray;
    sync_d[0]     = rd_ptr_gray_async;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    overflow_d = overflow_q;
    if (push && full_w) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_tx) begin
    if (rst_tx) begin
      wr_cnt_q      <= '0;
      wr_ptr_gray_q <= '0;
      overflow_q    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      wr_cnt_q      <= wr_cnt_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      overflow_q    <= overflow_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign wr_en       = push_ok;
  assign wr_addr     = wr_cnt_q[ADDR_W-1:0];
  assign wr_ptr_gray = wr_ptr_gray_q;
  assign full        = full_w;
  assign almost_full = (level_w >= AF_LVL);
  assign level       = level_w;
  assign overflow    = overflow_q;

endmodule
